// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory among NREQ requesters.
// Optional per-requester accept counters are enabled with the MEM_ARB_STATS_EN macro.
module mem_rr_arbiter #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned IDX_W      = $clog2(NREQ)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NREQ-1:0]            req_valid_i,
    input  logic [NREQ-1:0]            req_rd_wr_i,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NREQ*WIDTH-1:0]      req_wdata_i,
    output logic [NREQ-1:0]            req_ready_o,
    output logic [NREQ-1:0]            rsp_valid_o,
    output logic [WIDTH-1:0]           rsp_rdata_o,
    output logic                       mem_valid_o,
    output logic                       mem_rd_wr_o,
    output logic [ADDR_WIDTH-1:0]      mem_addr_o,
    output logic [WIDTH-1:0]           mem_wdata_o,
    input  logic                       mem_ready_i,
    input  logic [WIDTH-1:0]           mem_rdata_i
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]         grant_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        last_grant_q, last_grant_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic                    mem_valid_q, mem_valid_d;
    logic                    mem_rd_wr_q, mem_rd_wr_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]        mem_wdata_q, mem_wdata_d;
    logic [NREQ-1:0]         rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]        rsp_rdata_q, rsp_rdata_d;

    logic                    grant_found_c;
    logic [IDX_W-1:0]        grant_idx_c;
    logic [NREQ-1:0]         grant_c;
    logic                    accept_c;

    // First valid requester after the last grant, wrapping modulo NREQ
    always_comb begin
        int unsigned idx;
        idx           = 0;
        grant_found_c = 1'b0;
        grant_idx_c   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last_grant_q) + k) % NREQ;
            if (!grant_found_c && req_valid_i[IDX_W'(idx)]) begin
                grant_found_c = 1'b1;
                grant_idx_c   = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        grant_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            grant_c[i] = grant_found_c && (state_q == S_IDLE) && !rst_i
                         && (grant_idx_c == IDX_W'(i));
        end
    end

    assign accept_c    = |grant_c;
    assign req_ready_o = grant_c;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        mem_valid_d  = 1'b0;
        mem_rd_wr_d  = mem_rd_wr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d      = S_ISSUE;
                    owner_d      = grant_idx_c;
                    last_grant_d = grant_idx_c;
                    mem_valid_d  = 1'b1;
                    mem_rd_wr_d  = req_rd_wr_i[grant_idx_c];
                    mem_addr_d   = req_addr_i[grant_idx_c*ADDR_WIDTH +: ADDR_WIDTH];
                    mem_wdata_d  = req_wdata_i[grant_idx_c*WIDTH +: WIDTH];
                end
            end
            S_ISSUE: state_d = S_RESP;
            S_RESP: begin
                // A stalled memory keeps the arbiter here; no other grant meanwhile
                if (mem_ready_i) begin
                    state_d = S_IDLE;
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        rsp_valid_d[i] = (owner_q == IDX_W'(i));
                    end
                    rsp_rdata_d = mem_rd_wr_q ? '0 : mem_rdata_i;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            last_grant_q <= IDX_W'(NREQ - 1);
            owner_q      <= '0;
            mem_valid_q  <= 1'b0;
            mem_rd_wr_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            mem_valid_q  <= mem_valid_d;
            mem_rd_wr_q  <= mem_rd_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign mem_valid_o = mem_valid_q;
    assign mem_rd_wr_o = mem_rd_wr_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] grant_cnt_q [NREQ];

    // Saturating accept counters, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (grant_c[i] && (grant_cnt_q[i] != 16'hFFFF)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        grant_cnt_o = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            grant_cnt_o[i*16 +: 16] = grant_cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: transaction-level reference model plus a behavioural memory.
// Define MEM_ARB_STATS_EN on both files to also check the accept counters.
module tb_mem_rr_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [NREQ-1:0]      req_valid_i;
    logic [NREQ-1:0]      req_rd_wr_i;
    logic [NREQ*AW-1:0]   req_addr_i;
    logic [NREQ*WIDTH-1:0] req_wdata_i;
    logic [NREQ-1:0]      req_ready_o;
    logic [NREQ-1:0]      rsp_valid_o;
    logic [WIDTH-1:0]     rsp_rdata_o;
    logic                 mem_valid_o;
    logic                 mem_rd_wr_o;
    logic [AW-1:0]        mem_addr_o;
    logic [WIDTH-1:0]     mem_wdata_o;
    logic                 mem_ready_i;
    logic [WIDTH-1:0]     mem_rdata_i;
`ifdef MEM_ARB_STATS_EN
    logic [NREQ*16-1:0]   grant_cnt_o;
`endif

    mem_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_rd_wr_i (req_rd_wr_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .mem_valid_o (mem_valid_o),
        .mem_rd_wr_o (mem_rd_wr_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ready_i (mem_ready_i),
        .mem_rdata_i (mem_rdata_i)
`ifdef MEM_ARB_STATS_EN
        ,
        .grant_cnt_o (grant_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: one outstanding transaction, rotating priority pointer
    int          cyc = 0;
    bit          busy;
    int          last_g;
    int          acc_cyc, rsp_cyc;
    int          own, rsp_own;
    logic        e_rw;
    logic [3:0]  e_addr;
    logic [7:0]  e_wdata, e_rdata, rsp_dat;
    logic [7:0]  ref_mem [DEPTH];
    int          cnt [NREQ];

    // Behavioural memory
    logic [7:0]  tb_mem [DEPTH];
    bit          mem_pend;
    int          stall;
    int          max_stall;
    logic        p_rw;
    logic [3:0]  p_addr;
    logic [7:0]  p_wdata;

    // Observed DUT activity for directed checks
    int          obs_acc [$];
    logic [3:0]  obs_rspv;
    logic [7:0]  obs_rspd;
    bit          last_acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        busy     = 1'b0;
        last_g   = NREQ - 1;
        acc_cyc  = -10;
        rsp_cyc  = -10;
        e_rw     = 1'b0;
        e_addr   = '0;
        e_wdata  = '0;
        mem_pend = 1'b0;
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        obs_acc.delete();
    endtask

    // One clock cycle: entered and left at a falling edge
    task automatic do_cycle(input logic [3:0] v, input logic [3:0] rw,
                            input logic [15:0] a, input logic [31:0] d);
        logic [3:0]  exp_ready;
        logic [3:0]  exp_rspv;
        logic [63:0] exp_cnt;
        int          g;
        int          idx;
        mem_ready_i = 1'b0;
        mem_rdata_i = 8'($urandom);
        if (mem_pend) begin
            if (stall == 0) begin
                mem_ready_i = 1'b1;
                mem_rdata_i = p_rw ? 8'($urandom) : tb_mem[p_addr];
                if (p_rw) tb_mem[p_addr] = p_wdata;
                mem_pend = 1'b0;
            end else begin
                stall--;
            end
        end
        req_valid_i = v;
        req_rd_wr_i = rw;
        req_addr_i  = a;
        req_wdata_i = d;
        #1;
        if (cyc == rsp_cyc) busy = 1'b0;
        exp_ready = '0;
        g = -1;
        if (!busy) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (last_g + k) % NREQ;
                if (g < 0 && v[idx]) g = idx;
            end
            if (g >= 0) exp_ready = 4'(1 << g);
        end
        exp_rspv = (cyc == rsp_cyc) ? 4'(1 << rsp_own) : 4'd0;
        check("ready", 64'(req_ready_o), 64'(exp_ready));
        check("mem_valid", 64'(mem_valid_o), 64'(cyc == acc_cyc + 1));
        check("mem_cmd", 64'({mem_rd_wr_o, mem_addr_o, mem_wdata_o}), 64'({e_rw, e_addr, e_wdata}));
        check("rsp_valid", 64'(rsp_valid_o), 64'(exp_rspv));
        check("rsp_rdata", 64'(rsp_rdata_o), 64'((cyc == rsp_cyc) ? rsp_dat : 8'd0));
`ifdef MEM_ARB_STATS_EN
        exp_cnt = '0;
        for (int i = 0; i < NREQ; i++) exp_cnt[i*16 +: 16] = 16'(cnt[i]);
        check("grant_cnt", grant_cnt_o, exp_cnt);
`else
        exp_cnt = '0;
`endif
        for (int i = 0; i < NREQ; i++) if (req_ready_o[i] && v[i]) obs_acc.push_back(i);
        if (rsp_valid_o != 0) begin
            obs_rspv = rsp_valid_o;
            obs_rspd = rsp_rdata_o;
        end
        if (mem_valid_o) begin
            mem_pend = 1'b1;
            p_rw     = mem_rd_wr_o;
            p_addr   = mem_addr_o;
            p_wdata  = mem_wdata_o;
            stall    = $urandom_range(max_stall, 0);
        end
        if (mem_ready_i && busy) begin
            rsp_cyc = cyc + 1;
            rsp_own = own;
            rsp_dat = e_rdata;
        end
        last_acc = (g >= 0);
        if (g >= 0) begin
            busy    = 1'b1;
            acc_cyc = cyc;
            own     = g;
            last_g  = g;
            e_rw    = rw[g];
            e_addr  = a[g*4 +: 4];
            e_wdata = d[g*8 +: 8];
            e_rdata = e_rw ? 8'd0 : ref_mem[e_addr];
            if (e_rw) ref_mem[e_addr] = e_wdata;
            if (cnt[g] < 65535) cnt[g]++;
        end
        @(posedge clk_i);
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        req_valid_i = '0;
        mem_ready_i = 1'b0;
        repeat (2) begin
            @(posedge clk_i);
            cyc++;
            @(negedge clk_i);
        end
        check("rst_outs", 64'({req_ready_o, rsp_valid_o, rsp_rdata_o, mem_valid_o,
                               mem_rd_wr_o, mem_addr_o, mem_wdata_o}), 64'd0);
`ifdef MEM_ARB_STATS_EN
        check("rst_cnt", grant_cnt_o, 64'd0);
`endif
        rst_i = 1'b0;
        model_reset();
    endtask

    // Hold one requester's request until accepted, then let it complete
    task automatic run_req(input int n, input logic rw, input logic [3:0] addr, input logic [7:0] wd);
        logic [15:0] a;
        logic [31:0] d;
        bit          done;
        done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            a = 16'($urandom);
            d = $urandom;
            a[n*4 +: 4] = addr;
            d[n*8 +: 8] = wd;
            do_cycle(4'(1 << n), 4'(rw) << n, a, d);
            done = last_acc;
        end
        check("accept_timeout", 64'(done), 64'd1);
        repeat (4) do_cycle(4'd0, 4'($urandom), 16'($urandom), $urandom);
    endtask

    int exp_order [6];

    initial begin
        rst_i       = 1'b1;
        req_valid_i = '0;
        req_rd_wr_i = '0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        max_stall   = 0;
        for (int i = 0; i < DEPTH; i++) begin
            tb_mem[i]  = 8'($urandom);
            ref_mem[i] = tb_mem[i];
        end
        @(negedge clk_i);
        do_reset();

        // All four requesting: strict rotation starting from requester 0
        repeat (18) do_cycle(4'b1111, 4'($urandom), 16'($urandom), $urandom);
        exp_order = '{0, 1, 2, 3, 0, 1};
        check("rr_count", 64'(obs_acc.size()), 64'd6);
        for (int i = 0; i < 6 && i < obs_acc.size(); i++) check("rr_order", 64'(obs_acc[i]), 64'(exp_order[i]));
`ifdef MEM_ARB_STATS_EN
        check("stats_6", grant_cnt_o, {16'd1, 16'd1, 16'd2, 16'd2});
`endif

        do_reset();
        repeat (12) do_cycle(4'b1010, 4'($urandom), 16'($urandom), $urandom);
        exp_order = '{1, 3, 1, 3, 0, 0};
        check("rr2_count", 64'(obs_acc.size()), 64'd4);
        for (int i = 0; i < 4 && i < obs_acc.size(); i++) check("rr2_order", 64'(obs_acc[i]), 64'(exp_order[i]));

        // Single read of a known location
        tb_mem[5]  = 8'hA7;
        ref_mem[5] = 8'hA7;
        obs_rspv = '0;
        obs_rspd = '0;
        run_req(2, 1'b0, 4'd5, 8'h00);
        check("rd5_owner", 64'(obs_rspv), 64'(4'b0100));
        check("rd5_data", 64'(obs_rspd), 64'(8'hA7));

        // Write then read back through requester 1
        obs_rspv = '0;
        obs_rspd = 8'hFF;
        run_req(1, 1'b1, 4'd9, 8'h3C);
        check("wr9_owner", 64'(obs_rspv), 64'(4'b0010));
        check("wr9_data", 64'(obs_rspd), 64'd0);
        obs_rspv = '0;
        run_req(1, 1'b0, 4'd9, 8'h00);
        check("rd9_data", 64'(obs_rspd), 64'(8'h3C));

        // Random traffic with occasional memory stalls
        max_stall = 3;
        for (int i = 0; i < 800; i++) begin
            do_cycle(4'($urandom), 4'($urandom), 16'($urandom), $urandom);
        end
        max_stall = 0;
        repeat (6) do_cycle(4'd0, 4'd0, 16'd0, 32'd0);

        // Reset while the command is on the memory bus
        do_reset();
        do_cycle(4'b0100, 4'b0000, 16'($urandom), $urandom);
        check("mid_accept", 64'(last_acc), 64'd1);
        do_reset();
        repeat (6) do_cycle(4'd0, 4'd0, 16'd0, 32'd0);
        do_cycle(4'b1111, 4'($urandom), 16'($urandom), $urandom);
        check("post_rst_first", 64'(obs_acc.size() > 0 ? obs_acc[0] : 99), 64'd0);
        repeat (6) do_cycle(4'd0, 4'd0, 16'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
